// File: rtl/score_pulse_gen.sv
// score_pulse_gen: turns one-cycle brick hits into trains of score pulses for the BCD counters.
// Define SCORE_SOUND_EN to add SCORE_TONE, which is high while either score pulse is high.
module score_pulse_gen #(
    parameter int PULSE_HI = 4,
    parameter int PULSE_LO = 4,
    parameter int PEND_W   = 5
) (
    input  logic       CLK_DRV,
    input  logic       RESET_N,
    input  logic       START_GAME_N,
    input  logic       BRICK_HIT,
    input  logic [2:0] BRICK_ROW,
    input  logic       PLAYER2,
    output logic       COUNT_1,
    output logic       COUNT_2,
`ifdef SCORE_SOUND_EN
    output logic       SCORE_TONE,
`endif
    output logic       SCORE_BUSY
);

    localparam int TMAX = (PULSE_HI > PULSE_LO) ? PULSE_HI : PULSE_LO;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int SW   = PEND_W + 4;
    localparam logic [SW-1:0] PMAX = SW'((1 << PEND_W) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic [TW-1:0]     r_timer;
    logic [TW-1:0]     w_timerNext;
    logic              r_plyr;
    logic              w_plyrNext;
    logic              w_dec;
    logic [PEND_W-1:0] r_pending;
    logic [PEND_W-1:0] w_pendNext;
    logic [SW-1:0]     w_sum;
    logic [2:0]        w_val;
    logic              r_count1;
    logic              r_count2;
    logic              r_busy;
`ifdef SCORE_SOUND_EN
    logic              r_tone;
`endif

    // Row pairs score 1/3/5/7, which is simply the row number with bit 0 forced high.
    assign w_val = BRICK_ROW | 3'b001;

    always_comb begin
        w_stateNext = r_state;
        w_timerNext = r_timer;
        w_plyrNext  = r_plyr;
        w_dec       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending != '0) begin
                    w_stateNext = S_HIGH;
                    w_timerNext = TW'(PULSE_HI - 1);
                    w_plyrNext  = PLAYER2;
                    w_dec       = 1'b1;
                end
            end
            S_HIGH: begin
                if (r_timer == '0) begin
                    w_stateNext = S_LOW;
                    w_timerNext = TW'(PULSE_LO - 1);
                end else begin
                    w_timerNext = r_timer - 1'b1;
                end
            end
            S_LOW: begin
                if (r_timer == '0) begin
                    if (r_pending != '0) begin
                        w_stateNext = S_HIGH;
                        w_timerNext = TW'(PULSE_HI - 1);
                        w_plyrNext  = PLAYER2;
                        w_dec       = 1'b1;
                    end else begin
                        w_stateNext = S_IDLE;
                    end
                end else begin
                    w_timerNext = r_timer - 1'b1;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_timerNext = '0;
            end
        endcase

        // A hit and the point being dispensed on the same edge net out before saturating.
        w_sum      = SW'(r_pending) + (BRICK_HIT ? SW'(w_val) : '0) - SW'(w_dec);
        w_pendNext = (w_sum > PMAX) ? '1 : w_sum[PEND_W-1:0];
    end

    always_ff @(posedge CLK_DRV or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_plyr    <= 1'b0;
            r_pending <= '0;
            r_count1  <= 1'b0;
            r_count2  <= 1'b0;
            r_busy    <= 1'b0;
`ifdef SCORE_SOUND_EN
            r_tone    <= 1'b0;
`endif
        end else if (!START_GAME_N) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_pending <= '0;
            r_count1  <= 1'b0;
            r_count2  <= 1'b0;
            r_busy    <= 1'b0;
`ifdef SCORE_SOUND_EN
            r_tone    <= 1'b0;
`endif
        end else begin
            r_state   <= w_stateNext;
            r_timer   <= w_timerNext;
            r_plyr    <= w_plyrNext;
            r_pending <= w_pendNext;
            r_count1  <= (w_stateNext == S_HIGH) && !w_plyrNext;
            r_count2  <= (w_stateNext == S_HIGH) && w_plyrNext;
            r_busy    <= (w_pendNext != '0) || (w_stateNext != S_IDLE);
`ifdef SCORE_SOUND_EN
            r_tone    <= (w_stateNext == S_HIGH);
`endif
        end
    end

    assign COUNT_1    = r_count1;
    assign COUNT_2    = r_count2;
    assign SCORE_BUSY = r_busy;
`ifdef SCORE_SOUND_EN
    assign SCORE_TONE = r_tone;
`endif

endmodule

// File: tb/tb_score_pulse_gen.sv
// tb_score_pulse_gen: drives score_pulse_gen with directed and random hits and compares every
// cycle against a pulse-train model built from point totals and a position within the period.
module tb_score_pulse_gen;

    localparam int PH   = 4;
    localparam int PL   = 4;
    localparam int PW   = 5;
    localparam int PMAX = (1 << PW) - 1;

    logic       CLK_DRV      = 1'b0;
    logic       RESET_N      = 1'b1;
    logic       START_GAME_N = 1'b1;
    logic       BRICK_HIT    = 1'b0;
    logic [2:0] BRICK_ROW    = 3'd0;
    logic       PLAYER2      = 1'b0;
    logic       COUNT_1;
    logic       COUNT_2;
    logic       SCORE_BUSY;
`ifdef SCORE_SOUND_EN
    logic       SCORE_TONE;
`endif

    int vectors     = 0;
    int miscompares = 0;

    int mPend   = 0;
    int mPos    = 0;
    int mRises  = 0;
    bit mActive = 1'b0;
    bit mPlyr   = 1'b0;

    score_pulse_gen #(.PULSE_HI(PH), .PULSE_LO(PL), .PEND_W(PW)) dut (
        .CLK_DRV     (CLK_DRV),
        .RESET_N     (RESET_N),
        .START_GAME_N(START_GAME_N),
        .BRICK_HIT   (BRICK_HIT),
        .BRICK_ROW   (BRICK_ROW),
        .PLAYER2     (PLAYER2),
        .COUNT_1     (COUNT_1),
        .COUNT_2     (COUNT_2),
`ifdef SCORE_SOUND_EN
        .SCORE_TONE  (SCORE_TONE),
`endif
        .SCORE_BUSY  (SCORE_BUSY)
    );

    always #5 CLK_DRV = ~CLK_DRV;

    task automatic modelReset();
        mPend   = 0;
        mPos    = 0;
        mActive = 1'b0;
        mPlyr   = 1'b0;
    endtask

    // One clock edge of the reference: a pulse starts whenever points are owed and the
    // previous period (PH high + PL low) has fully elapsed.
    task automatic modelStep();
        int val;
        bit startPulse;
        if (!RESET_N) begin
            modelReset();
        end else if (!START_GAME_N) begin
            mPend   = 0;
            mPos    = 0;
            mActive = 1'b0;
        end else begin
            val        = BRICK_HIT ? 2 * int'(BRICK_ROW[2:1]) + 1 : 0;
            startPulse = (mPend != 0) && (!mActive || mPos == PH + PL - 1);
            if (startPulse) begin
                mActive = 1'b1;
                mPos    = 0;
                mPlyr   = PLAYER2;
                mRises++;
            end else if (mActive) begin
                if (mPos == PH + PL - 1) mActive = 1'b0;
                else mPos++;
            end
            mPend = mPend + val - (startPulse ? 1 : 0);
            if (mPend > PMAX) mPend = PMAX;
        end
    endtask

    function automatic logic [3:0] expVec();
        logic c1, c2;
        c1 = mActive && (mPos < PH) && !mPlyr;
        c2 = mActive && (mPos < PH) && mPlyr;
        return {c1, c2, (mPend != 0) || mActive, c1 | c2};
    endfunction

    function automatic logic [3:0] obsVec();
`ifdef SCORE_SOUND_EN
        return {COUNT_1, COUNT_2, SCORE_BUSY, SCORE_TONE};
`else
        return {COUNT_1, COUNT_2, SCORE_BUSY, COUNT_1 | COUNT_2};
`endif
    endfunction

    task automatic tick();
        @(posedge CLK_DRV);
        modelStep();
        @(negedge CLK_DRV);
    endtask

    task automatic test_reset();
        #2 RESET_N = 1'b0;
        #1 modelReset();
        vectors++;
        if (obsVec() !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL reset_async: got %b expected %b", obsVec(), expVec());
        end
        repeat (2) tick();
        RESET_N = 1'b1;
        tick();
        vectors++;
        if (obsVec() !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got %b expected %b", obsVec(), expVec());
        end
    endtask

    task automatic test_single_hit();
        int highs = 0;
        int rises = 0;
        logic prev = 1'b0;
        BRICK_HIT = 1'b1; BRICK_ROW = 3'd0; PLAYER2 = 1'b0;
        tick();
        BRICK_HIT = 1'b0;
        vectors++;
        if (COUNT_1 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_early: COUNT_1 %b expected 0", COUNT_1);
        end
        for (int c = 0; c < 14; c++) begin
            tick();
            if (c == 0) begin
                vectors++;
                if (COUNT_1 !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL single_latency: COUNT_1 %b expected 1", COUNT_1);
                end
            end
            vectors++;
            if (obsVec() !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL single_cycle %0d: got %b expected %b", c, obsVec(), expVec());
            end
            if (COUNT_1 === 1'b1) highs++;
            if (COUNT_1 === 1'b1 && prev === 1'b0) rises++;
            prev = COUNT_1;
        end
        vectors++;
        if (highs != PH || rises != 1 || SCORE_BUSY !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_shape: highs %0d rises %0d busy %b expected %0d 1 0",
                     highs, rises, SCORE_BUSY, PH);
        end
    endtask

    task automatic test_player2_train();
        int rises2 = 0;
        int rises1 = 0;
        int lastRise = -1;
        int badPeriods = 0;
        logic p1 = 1'b0;
        logic p2 = 1'b0;
        BRICK_HIT = 1'b1; BRICK_ROW = 3'd7; PLAYER2 = 1'b1;
        tick();
        BRICK_HIT = 1'b0;
        for (int c = 0; c < 64; c++) begin
            tick();
            vectors++;
            if (obsVec() !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL p2_cycle %0d: got %b expected %b", c, obsVec(), expVec());
            end
            if (COUNT_2 === 1'b1 && p2 === 1'b0) begin
                if (lastRise >= 0 && c - lastRise != PH + PL) badPeriods++;
                lastRise = c;
                rises2++;
            end
            if (COUNT_1 === 1'b1 && p1 === 1'b0) rises1++;
            p1 = COUNT_1;
            p2 = COUNT_2;
        end
        vectors++;
        if (rises2 != 7 || rises1 != 0 || badPeriods != 0) begin
            miscompares++;
            $display("[TB] FAIL p2_train: c2 rises %0d c1 rises %0d bad periods %0d expected 7 0 0",
                     rises2, rises1, badPeriods);
        end
        PLAYER2 = 1'b0;
    endtask

    task automatic test_accumulate();
        int rises = 0;
        int lowRun = 0;
        int maxGap = 0;
        bit hitSent = 1'b0;
        logic prev = 1'b0;
        BRICK_HIT = 1'b1; BRICK_ROW = 3'd5; PLAYER2 = 1'b0;
        tick();
        BRICK_HIT = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (rises == 2 && !hitSent) begin
                BRICK_HIT = 1'b1;
                BRICK_ROW = 3'd2;
                hitSent   = 1'b1;
            end
            tick();
            BRICK_HIT = 1'b0;
            vectors++;
            if (obsVec() !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL accum_cycle %0d: got %b expected %b", c, obsVec(), expVec());
            end
            if (COUNT_1 === 1'b1 && prev === 1'b0) begin
                if (rises > 0 && lowRun > maxGap) maxGap = lowRun;
                rises++;
            end
            lowRun = (COUNT_1 === 1'b1) ? 0 : lowRun + 1;
            prev = COUNT_1;
        end
        vectors++;
        if (!hitSent || rises != 8 || maxGap > PL) begin
            miscompares++;
            $display("[TB] FAIL accum_train: sent %0d rises %0d max gap %0d expected 1 8 <=%0d",
                     hitSent, rises, maxGap, PL);
        end
    endtask

    task automatic test_saturation();
        int rises = 0;
        int modelStart = mRises;
        logic prev = 1'b0;
        PLAYER2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            BRICK_HIT = 1'b1; BRICK_ROW = 3'd7;
            tick();
            if (COUNT_1 === 1'b1 && prev === 1'b0) rises++;
            prev = COUNT_1;
        end
        BRICK_HIT = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick();
            vectors++;
            if (obsVec() !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL sat_cycle %0d: got %b expected %b", c, obsVec(), expVec());
            end
            if (COUNT_1 === 1'b1 && prev === 1'b0) rises++;
            prev = COUNT_1;
        end
        vectors++;
        if (rises != mRises - modelStart) begin
            miscompares++;
            $display("[TB] FAIL sat_count: rises %0d expected %0d", rises, mRises - modelStart);
        end
    endtask

    task automatic test_start_clear();
        int rises = 0;
        int lateRises = 0;
        bit cleared = 1'b0;
        logic prev = 1'b0;
        BRICK_HIT = 1'b1; BRICK_ROW = 3'd6; PLAYER2 = 1'b0;
        tick();
        BRICK_HIT = 1'b0;
        for (int c = 0; c < 70; c++) begin
            if (rises == 3 && !cleared) START_GAME_N = 1'b0;
            tick();
            if (!START_GAME_N) begin
                START_GAME_N = 1'b1;
                cleared      = 1'b1;
                vectors++;
                if ({COUNT_1, COUNT_2, SCORE_BUSY} !== 3'b000) begin
                    miscompares++;
                    $display("[TB] FAIL clear_now: got %b expected 000", {COUNT_1, COUNT_2, SCORE_BUSY});
                end
            end
            vectors++;
            if (obsVec() !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL clear_cycle %0d: got %b expected %b", c, obsVec(), expVec());
            end
            if ((COUNT_1 | COUNT_2) === 1'b1 && prev === 1'b0) begin
                rises++;
                if (cleared) lateRises++;
            end
            prev = COUNT_1 | COUNT_2;
        end
        vectors++;
        if (!cleared || lateRises != 0 || SCORE_BUSY !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clear_after: cleared %0d late rises %0d busy %b expected 1 0 0",
                     cleared, lateRises, SCORE_BUSY);
        end
    endtask

    task automatic test_async_reset();
        int rises = 0;
        bit seenHigh = 1'b0;
        logic prev = 1'b0;
        BRICK_HIT = 1'b1; BRICK_ROW = 3'd4; PLAYER2 = 1'b1;
        tick();
        BRICK_HIT = 1'b0;
        for (int c = 0; c < 10 && !seenHigh; c++) begin
            tick();
            seenHigh = (COUNT_2 === 1'b1);
        end
        #2 RESET_N = 1'b0;
        #1;
        vectors++;
        if (!seenHigh || obsVec() !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL async_reset: seen high %0d got %b expected 0000", seenHigh, obsVec());
        end
        modelReset();
        @(negedge CLK_DRV);
        RESET_N = 1'b1;
        PLAYER2 = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            vectors++;
            if (obsVec() !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL post_reset %0d: got %b expected %b", c, obsVec(), expVec());
            end
            if ((COUNT_1 | COUNT_2) === 1'b1 && prev === 1'b0) rises++;
            prev = COUNT_1 | COUNT_2;
        end
        vectors++;
        if (rises != 0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_pulses: rises %0d expected 0", rises);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            BRICK_HIT    = ($urandom_range(0, 5) == 0);
            BRICK_ROW    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) PLAYER2 = ~PLAYER2;
            START_GAME_N = ($urandom_range(0, 149) != 0);
            tick();
            vectors++;
            if (obsVec() !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL random_cycle %0d: got %b expected %b", c, obsVec(), expVec());
            end
        end
        BRICK_HIT    = 1'b0;
        START_GAME_N = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_player2_train();
        test_accumulate();
        test_saturation();
        test_start_clear();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
